// File: rtl/fetch_queue.sv
// fetch_queue
//   Fetch stage plus decoupling FIFO for the pipelined RV32I core. It owns
//   the fetch PC, reads a combinational instruction memory, and queues
//   {pc, instr} pairs for decode behind a valid/ready handshake. A redirect
//   from execute flushes the queue and reloads the PC.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   trigger_i       start request; latched into run (ignored once run=1)
//   imem_addr_o     fetch address (registered PC)
//   imem_req_o      current PC is fetched and pushed this cycle
//   imem_data_i     instruction at imem_addr_o, same cycle
//   redirect_i      taken branch/jump; flushes the queue
//   redirect_pc_i   redirect target (low two bits dropped)
//   valid_o         head entry valid for decode
//   ready_i         decode accepts head
//   instr_o, pc_o   head instruction / PC (zero when not valid)
//   pc_plus_4_o     head PC + 4 (zero when not valid)
//   count_o         occupied entries
module fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger_i,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  output logic                  imem_req_o,
  input  logic [DATA_WIDTH-1:0] imem_data_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus_4_o,
  output logic [CNT_W-1:0]      count_o
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] pc;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  run;

  logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];

  logic                  valid;
  logic                  pop;
  logic                  push;
  logic                  not_full;
  logic [DATA_WIDTH-1:0] head_pc;
  logic [DATA_WIDTH-1:0] head_instr;

  // Redirect targets are word aligned; the two low bits are discarded.
  logic                  unused_low_bits;
  assign unused_low_bits = ^redirect_pc_i[1:0];

  // Handshake is masked during reset so nothing looks accepted while the
  // state is being cleared.
  assign not_full = (count < FULL_CNT);
  assign valid    = ~rst & (count != '0) & ~redirect_i;
  assign pop      = valid & ready_i;
  // A full queue can still take a fetch when the head leaves this cycle.
  assign push     = ~rst & run & ~redirect_i & (not_full | pop);

  // Control state: PC, pointers, occupancy, run latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      run    <= trigger_i;
    end else begin
      run <= run | trigger_i;
      if (redirect_i) begin
        pc     <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc     <= pc + DATA_WIDTH'(4);
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Queue storage: data only, never reset; occupancy lives in count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc;
      instr_mem[wr_ptr] <= imem_data_i;
    end
  end

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  assign imem_addr_o = pc;
  assign imem_req_o  = push;
  assign valid_o     = valid;
  assign instr_o     = valid ? head_instr : '0;
  assign pc_o        = valid ? head_pc : '0;
  assign pc_plus_4_o = valid ? (head_pc + DATA_WIDTH'(4)) : '0;
  assign count_o     = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (DATA_WIDTH=32, DEPTH=4, RESET_PC=0).
// The instruction memory is modelled as addr ^ 32'hA5A5_0000.
module tb_fetch_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             trigger_i;
  logic [DW-1:0]    imem_addr_o;
  logic             imem_req_o;
  logic [DW-1:0]    imem_data_i;
  logic             redirect_i;
  logic [DW-1:0]    redirect_pc_i;
  logic             valid_o;
  logic             ready_i;
  logic [DW-1:0]    instr_o;
  logic [DW-1:0]    pc_o;
  logic [DW-1:0]    pc_plus_4_o;
  logic [CNT_W-1:0] count_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_data_i = imem_addr_o ^ 32'hA5A5_0000;

  fetch_queue #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .trigger_i    (trigger_i),
    .imem_addr_o  (imem_addr_o),
    .imem_req_o   (imem_req_o),
    .imem_data_i  (imem_data_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .pc_plus_4_o  (pc_plus_4_o),
    .count_o      (count_o)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    trigger_i     = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    ready_i       = 1'b0;

    // Reset with trigger low
    tick(); tick();
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_req",   32'(imem_req_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_addr",  imem_addr_o, 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc",    pc_o, 32'h0);
    chk("rst_pc4",   pc_plus_4_o, 32'h0);

    rst = 1'b0;
    tick(); tick(); tick();
    chk("idle_req",   32'(imem_req_o), 32'd0);
    chk("idle_valid", 32'(valid_o), 32'd0);
    chk("idle_count", 32'(count_o), 32'd0);
    chk("idle_addr",  imem_addr_o, 32'h0);

    // Trigger pulse arms fetch
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    #1;
    chk("arm_req",   32'(imem_req_o), 32'd1);
    chk("arm_addr",  imem_addr_o, 32'h0);
    chk("arm_valid", 32'(valid_o), 32'd0);
    tick();
    chk("first_valid", 32'(valid_o), 32'd1);
    chk("first_pc",    pc_o, 32'h0);
    chk("first_pc4",   pc_plus_4_o, 32'h4);
    chk("first_instr", instr_o, 32'hA5A5_0000);
    chk("first_count", 32'(count_o), 32'd1);
    chk("first_addr",  imem_addr_o, 32'h4);

    // Streaming with decode always ready
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("stream_pc",    pc_o, 32'(4 * i));
      chk("stream_instr", instr_o, 32'(4 * i) ^ 32'hA5A5_0000);
      chk("stream_count", 32'(count_o), 32'd1);
      chk("stream_addr",  imem_addr_o, 32'(4 * (i + 1)));
      tick();
    end

    // Reset with trigger high, then fill with decode stalled
    rst       = 1'b1;
    trigger_i = 1'b1;
    ready_i   = 1'b0;
    tick();
    rst       = 1'b0;
    trigger_i = 1'b0;
    #1;
    chk("rearm_req",   32'(imem_req_o), 32'd1);
    chk("rearm_count", 32'(count_o), 32'd0);
    tick(); tick(); tick(); tick();
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_addr",  imem_addr_o, 32'h10);
    chk("full_req",   32'(imem_req_o), 32'd0);
    tick();
    chk("hold_count", 32'(count_o), 32'd4);
    chk("hold_addr",  imem_addr_o, 32'h10);
    chk("hold_pc",    pc_o, 32'h0);
    chk("hold_instr", instr_o, 32'hA5A5_0000);

    ready_i = 1'b1;
    #1;
    chk("fullpop_req",   32'(imem_req_o), 32'd1);
    chk("fullpop_valid", 32'(valid_o), 32'd1);
    chk("fullpop_pc",    pc_o, 32'h0);
    tick();
    chk("fullpop_count", 32'(count_o), 32'd4);
    chk("fullpop_head",  pc_o, 32'h4);
    chk("fullpop_addr",  imem_addr_o, 32'h14);
    tick();
    chk("q8_head",  pc_o, 32'h8);
    chk("q8_count", 32'(count_o), 32'd4);

    // Redirect flushes the queue holding pcs 8..20
    ready_i       = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    #1;
    chk("redir_valid", 32'(valid_o), 32'd0);
    chk("redir_req",   32'(imem_req_o), 32'd0);
    tick();
    redirect_i = 1'b0;
    #1;
    chk("redir_count", 32'(count_o), 32'd0);
    chk("redir_addr",  imem_addr_o, 32'h100);
    chk("redir_req2",  32'(imem_req_o), 32'd1);
    tick();
    chk("redir_hvalid", 32'(valid_o), 32'd1);
    chk("redir_hpc",    pc_o, 32'h100);
    chk("redir_hinstr", instr_o, 32'hA5A5_0100);

    // Back-to-back redirects: last target wins
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    tick();
    redirect_pc_i = 32'h80;
    #1;
    chk("dbl_mid_addr", imem_addr_o, 32'h40);
    chk("dbl_mid_req",  32'(imem_req_o), 32'd0);
    tick();
    redirect_i = 1'b0;
    #1;
    chk("dbl_addr",  imem_addr_o, 32'h80);
    chk("dbl_count", 32'(count_o), 32'd0);
    tick();
    chk("dbl_head",  pc_o, 32'h80);
    chk("dbl_count2", 32'(count_o), 32'd1);

    // Reset while three entries are queued, trigger high
    tick(); tick();
    chk("pre_rst_count", 32'(count_o), 32'd3);
    rst       = 1'b1;
    trigger_i = 1'b1;
    tick();
    rst       = 1'b0;
    trigger_i = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count_o), 32'd0);
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_addr",  imem_addr_o, 32'h0);
    chk("mid_rst_req",   32'(imem_req_o), 32'd1);
    tick();
    chk("mid_rst_head",  pc_o, 32'h0);
    chk("mid_rst_cnt1",  32'(count_o), 32'd1);

    // PC wrap at the top of the address space
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFF;
    tick();
    redirect_i = 1'b0;
    #1;
    chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    chk("wrap_head", pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc4",  pc_plus_4_o, 32'h0);
    chk("wrap_next", imem_addr_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
